// File: rtl/jts16_fd1094_pkg.sv
// Shared definitions for the FD1094 state tracker and related bus snoopers.
package jts16_fd1094_pkg;

    typedef enum logic [2:0] {
        ST_INIT = 3'd0,
        ST_VEC  = 3'd1,
        ST_RUN  = 3'd2,
        ST_CMP1 = 3'd3,
        ST_CMP2 = 3'd4
    } fd_state_t;

    localparam logic [15:0] OP_CMPIL_D0 = 16'h0C80;
    localparam logic [15:0] OP_RTE      = 16'h4E73;

    // Reset vector: initial SSP and PC, two words each
    localparam int unsigned VEC_WORDS = 4;
    localparam logic [1:0]  VEC_LAST  = 2'(VEC_WORDS - 1);

endpackage

// File: rtl/jts16_busacc.sv
// One-shot accept pulse per CPU bus cycle: fires on the first valid-data clock
// with the strobe low, then waits for the strobe to go high before re-arming.
module jts16_busacc (
    input  logic clk,
    input  logic rst,
    input  logic asn,
    input  logic rom_ok,
    output logic acc
);

    logic armed;

    assign acc = armed & ~asn & rom_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            armed <= 1'b0;
        else if (asn)
            armed <= 1'b1;
        else if (acc)
            armed <= 1'b0;
    end

endmodule

// File: rtl/jts16_fd1094_ctrl.sv
// FD1094 decryption-state tracker: follows the state-change sequence, interrupt
// acknowledge and RTE on decoded fetches, and drives st/vrq/dec_en to the decoder.
module jts16_fd1094_ctrl #(
    parameter logic [7:0] IRQ_ST = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [12:0] prog_addr,
    input  logic        fd1094_we,
    input  logic [7:0]  prog_data,
    input  logic        asn,
    input  logic        op_n,
    input  logic        inta,
    input  logic [23:1] addr,
    input  logic [15:0] dec,
    input  logic        rom_ok,
    output logic [7:0]  st,
    output logic        vrq,
    output logic        dec_en
);
    import jts16_fd1094_pkg::*;

    fd_state_t  state_q, state_d;
    logic [7:0] key0;
    logic [7:0] st_d, st_save, save_d;
    logic       vrq_d, dec_en_d, irq_mode, irq_d;
    logic [1:0] vec_cnt, cnt_d;
    logic       acc;
    logic       examine;
    logic       unused_addr;

    // Bus address is not needed to track the state; vector words are counted
    assign unused_addr = ^addr;

    jts16_busacc u_busacc (
        .clk    (clk),
        .rst    (rst),
        .asn    (asn),
        .rom_ok (rom_ok),
        .acc    (acc)
    );

    // Key survives reset, so no reset term here
    always_ff @(posedge clk) begin
        if (fd1094_we && prog_addr == 13'd0)
            key0 <= prog_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_INIT;
            st       <= 8'h00;
            vrq      <= 1'b1;
            dec_en   <= 1'b0;
            irq_mode <= 1'b0;
            st_save  <= 8'h00;
            vec_cnt  <= 2'd0;
        end else begin
            state_q  <= state_d;
            st       <= st_d;
            vrq      <= vrq_d;
            dec_en   <= dec_en_d;
            irq_mode <= irq_d;
            st_save  <= save_d;
            vec_cnt  <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        st_d     = st;
        vrq_d    = vrq;
        dec_en_d = dec_en;
        irq_d    = irq_mode;
        save_d   = st_save;
        cnt_d    = vec_cnt;
        examine  = 1'b0;

        case (state_q)
            ST_INIT: begin
                st_d     = key0;
                dec_en_d = 1'b1;
                state_d  = ST_VEC;
            end
            ST_VEC: begin
                if (acc) begin
                    cnt_d = vec_cnt + 2'd1;
                    if (vec_cnt == VEC_LAST) begin
                        vrq_d   = 1'b0;
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN, ST_CMP1, ST_CMP2: begin
                if (acc) begin
                    if (inta) begin
                        // Only the outermost interrupt records the state to restore
                        if (!irq_mode)
                            save_d = st;
                        irq_d   = 1'b1;
                        st_d    = IRQ_ST;
                        state_d = ST_RUN;
                    end else if (!op_n) begin
                        case (state_q)
                            ST_CMP1: begin
                                if (dec == 16'h0000)
                                    state_d = ST_CMP2;
                                else
                                    examine = 1'b1;
                            end
                            ST_CMP2: begin
                                if (dec[15:8] == 8'h00)
                                    st_d = dec[7:0];
                                state_d = ST_RUN;
                            end
                            default: examine = 1'b1;
                        endcase
                        // An aborted CMP1 word is treated as a fresh opcode
                        if (examine) begin
                            state_d = ST_RUN;
                            if (dec == OP_CMPIL_D0) begin
                                state_d = ST_CMP1;
                            end else if (dec == OP_RTE && irq_mode) begin
                                st_d  = st_save;
                                irq_d = 1'b0;
                            end
                        end
                    end
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

endmodule

// File: tb/tb_jts16_fd1094_ctrl.sv
// Directed bench for the FD1094 state tracker with hand-computed expectations.
module tb_jts16_fd1094_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [12:0] prog_addr;
    logic        fd1094_we;
    logic [7:0]  prog_data;
    logic        asn;
    logic        op_n;
    logic        inta;
    logic [23:1] addr;
    logic [15:0] dec;
    logic        rom_ok;
    logic [7:0]  st;
    logic        vrq;
    logic        dec_en;

    int checks = 0;
    int errors = 0;

    jts16_fd1094_ctrl #(.IRQ_ST(8'h00)) dut (
        .clk       (clk),
        .rst       (rst),
        .prog_addr (prog_addr),
        .fd1094_we (fd1094_we),
        .prog_data (prog_data),
        .asn       (asn),
        .op_n      (op_n),
        .inta      (inta),
        .addr      (addr),
        .dec       (dec),
        .rom_ok    (rom_ok),
        .st        (st),
        .vrq       (vrq),
        .dec_en    (dec_en)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One bus cycle: a single clock with strobe low and data valid, then idle.
    task automatic bus(input logic opn, input logic ia, input logic [15:0] d);
        op_n = opn; inta = ia; dec = d; asn = 1'b0; rom_ok = 1'b1;
        @(posedge clk); #1;
        asn = 1'b1; rom_ok = 1'b0; inta = 1'b0; op_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic fetch(input logic [15:0] d);
        bus(1'b0, 1'b0, d);
    endtask

    task automatic vector_reads();
        for (int unsigned i = 0; i < 4; i++) begin
            addr = 23'(i);
            bus(1'b1, 1'b0, 16'h1000 + 16'(i));
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; asn = 1'b1; rom_ok = 1'b0; op_n = 1'b1; inta = 1'b0;
        addr = '0; dec = '0; prog_addr = '0; prog_data = '0; fd1094_we = 1'b0;
        @(posedge clk); #1;
        fd1094_we = 1'b1; prog_data = 8'h5A;
        @(posedge clk); #1;
        fd1094_we = 1'b0;
        checks++; if (st !== 8'h00) begin errors++; $display("FAIL rst_st: st=%h expected 00", st); end
        checks++; if (vrq !== 1'b1) begin errors++; $display("FAIL rst_vrq: vrq=%b expected 1", vrq); end
        checks++; if (dec_en !== 1'b0) begin errors++; $display("FAIL rst_dec_en: dec_en=%b expected 0", dec_en); end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (st !== 8'h5A) begin errors++; $display("FAIL init_st: st=%h expected 5a", st); end
        checks++; if (dec_en !== 1'b1) begin errors++; $display("FAIL init_dec_en: dec_en=%b expected 1", dec_en); end
        checks++; if (vrq !== 1'b1) begin errors++; $display("FAIL init_vrq: vrq=%b expected 1", vrq); end
    endtask

    task automatic test_vector();
        for (int unsigned i = 0; i < 3; i++) begin
            addr = 23'(i);
            bus(1'b1, 1'b0, 16'h2000);
            checks++; if (vrq !== 1'b1) begin errors++; $display("FAIL vec_vrq_%0d: vrq=%b expected 1", i, vrq); end
        end
        addr = 23'd3;
        bus(1'b1, 1'b0, 16'h2000);
        checks++; if (vrq !== 1'b0) begin errors++; $display("FAIL vec_vrq_end: vrq=%b expected 0", vrq); end
        checks++; if (st !== 8'h5A) begin errors++; $display("FAIL vec_st: st=%h expected 5a", st); end
    endtask

    task automatic test_state_change();
        fetch(16'h0C80);
        fetch(16'h0000);
        checks++; if (st !== 8'h5A) begin errors++; $display("FAIL sc_pre: st=%h expected 5a", st); end
        op_n = 1'b0; dec = 16'h00A7; asn = 1'b0; rom_ok = 1'b1;
        @(posedge clk); #1;
        checks++; if (st !== 8'hA7) begin errors++; $display("FAIL sc_st: st=%h expected a7", st); end
        asn = 1'b1; rom_ok = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_aborted();
        fetch(16'h0C80); fetch(16'h0001); fetch(16'h00A7);
        checks++; if (st !== 8'hA7) begin errors++; $display("FAIL abort_st: st=%h expected a7", st); end
        fetch(16'h0C80); fetch(16'h0C80); fetch(16'h0000); fetch(16'h0033);
        checks++; if (st !== 8'h33) begin errors++; $display("FAIL reexam_st: st=%h expected 33", st); end
        fetch(16'h0C80); fetch(16'h0000); fetch(16'h01A7);
        checks++; if (st !== 8'h33) begin errors++; $display("FAIL cmp2_hi_st: st=%h expected 33", st); end
    endtask

    task automatic test_back_to_back();
        fetch(16'h0C80);
        // Long fetch: strobe held low for three clocks must count once
        op_n = 1'b0; dec = 16'h0000; asn = 1'b0; rom_ok = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        asn = 1'b1; rom_ok = 1'b0;
        @(posedge clk); #1;
        checks++; if (st !== 8'h33) begin errors++; $display("FAIL long_cycle_st: st=%h expected 33", st); end
        fetch(16'h00B1);
        checks++; if (st !== 8'hB1) begin errors++; $display("FAIL long_cycle_next: st=%h expected b1", st); end
    endtask

    task automatic test_irq();
        fetch(16'h0C80); fetch(16'h0000); fetch(16'h0021);
        checks++; if (st !== 8'h21) begin errors++; $display("FAIL irq_setup: st=%h expected 21", st); end
        bus(1'b1, 1'b1, 16'h0000);
        checks++; if (st !== 8'h00) begin errors++; $display("FAIL irq_enter: st=%h expected 00", st); end
        fetch(16'h0C80); fetch(16'h0000); fetch(16'h0044);
        checks++; if (st !== 8'h44) begin errors++; $display("FAIL irq_change: st=%h expected 44", st); end
        bus(1'b1, 1'b1, 16'h0000);
        checks++; if (st !== 8'h00) begin errors++; $display("FAIL irq_nested: st=%h expected 00", st); end
        fetch(16'h4E73);
        checks++; if (st !== 8'h21) begin errors++; $display("FAIL rte_restore: st=%h expected 21", st); end
    endtask

    task automatic test_spurious();
        fetch(16'h0C80); fetch(16'h0000); fetch(16'h0077);
        fetch(16'h4E73);
        checks++; if (st !== 8'h77) begin errors++; $display("FAIL spurious_rte: st=%h expected 77", st); end
        bus(1'b1, 1'b0, 16'h0C80); fetch(16'h0000); fetch(16'h0055);
        checks++; if (st !== 8'h77) begin errors++; $display("FAIL data_cmpi: st=%h expected 77", st); end
        fetch(16'h0C80); bus(1'b1, 1'b0, 16'h1234); fetch(16'h0000); fetch(16'h0066);
        checks++; if (st !== 8'h66) begin errors++; $display("FAIL data_in_cmp1: st=%h expected 66", st); end
        fetch(16'h0C80); fetch(16'h0000); bus(1'b1, 1'b0, 16'h0099); fetch(16'h0012);
        checks++; if (st !== 8'h12) begin errors++; $display("FAIL data_in_cmp2: st=%h expected 12", st); end
    endtask

    task automatic test_midreset();
        fetch(16'h0C80); fetch(16'h0000);
        #2 rst = 1'b1;
        #1;
        checks++; if (st !== 8'h00) begin errors++; $display("FAIL mid_rst_st: st=%h expected 00", st); end
        checks++; if (vrq !== 1'b1) begin errors++; $display("FAIL mid_rst_vrq: vrq=%b expected 1", vrq); end
        checks++; if (dec_en !== 1'b0) begin errors++; $display("FAIL mid_rst_dec_en: dec_en=%b expected 0", dec_en); end
        @(posedge clk); #1;
        // Key write lands on the same edge as INIT->VEC: old key must be used
        rst = 1'b0; fd1094_we = 1'b1; prog_addr = 13'd0; prog_data = 8'hC3;
        @(posedge clk); #1;
        fd1094_we = 1'b0;
        checks++; if (st !== 8'h5A) begin errors++; $display("FAIL key_race_st: st=%h expected 5a", st); end
        checks++; if (dec_en !== 1'b1) begin errors++; $display("FAIL mid_rel_dec_en: dec_en=%b expected 1", dec_en); end
        vector_reads();
        checks++; if (vrq !== 1'b0) begin errors++; $display("FAIL mid_vec_vrq: vrq=%b expected 0", vrq); end
        fetch(16'h0000);
        checks++; if (st !== 8'h5A) begin errors++; $display("FAIL mid_st_kept: st=%h expected 5a", st); end
        rst = 1'b1;
        fd1094_we = 1'b1; prog_addr = 13'd1; prog_data = 8'hFF;
        @(posedge clk); #1;
        fd1094_we = 1'b0; prog_addr = 13'd0; rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (st !== 8'hC3) begin errors++; $display("FAIL key_new_st: st=%h expected c3", st); end
        vector_reads();
        fetch(16'h0C80); fetch(16'h0000); fetch(16'h0009);
        checks++; if (st !== 8'h09) begin errors++; $display("FAIL post_rst_sc: st=%h expected 09", st); end
    endtask

    initial begin
        test_reset();
        test_vector();
        test_state_change();
        test_aborted();
        test_back_to_back();
        test_irq();
        test_spurious();
        test_midreset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
